// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_unit
// Description : Word PC register plus next-PC sequencer (sequential/branch/jump)
//               with BOOT/RUN/HALT control; optional redirect counter enabled
//               by macro PC_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
  parameter logic [29:0] RESET_VEC = 30'h00100000,
  parameter int          PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  input  logic [15:0]       imm16_i,
  input  logic [25:0]       target26_i,
  output logic [29:0]       pc_o,
  output logic [31:0]       pc_byte_o,
  output logic [29:0]       pc_plus1_o,
  output logic              valid_o,
  output logic              halted_o,
  output logic [PERF_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [29:0] r_pc;
  logic        r_valid;
  logic        r_halted;

  logic [29:0] w_pc_plus1;
  logic [29:0] w_imm_sext;
  logic [29:0] w_branch_target;

  assign w_pc_plus1      = r_pc + 30'd1;
  assign w_imm_sext      = {{14{imm16_i[15]}}, imm16_i};
  // Single adder with carry-in: pc + sext(imm) + 1, wraps modulo 2^30.
  assign w_branch_target = r_pc + w_imm_sext + 30'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_VEC;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
          r_valid <= 1'b1;
        end
        S_RUN: begin
          if (halt_i) begin
            r_state  <= S_HALT;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
          end else if (stall_i) begin
            r_pc <= r_pc;
          end else if (jump_i) begin
            r_pc <= {w_pc_plus1[29:26], target26_i};
          end else if (branch_taken_i) begin
            r_pc <= w_branch_target;
          end else begin
            r_pc <= w_pc_plus1;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state  <= S_HALT;
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

`ifdef PC_PERF_CNT_EN
  logic              w_redirect;
  logic [PERF_W-1:0] r_redirect_cnt;

  assign w_redirect = (r_state == S_RUN) && !halt_i && !stall_i &&
                      (jump_i || branch_taken_i);

  // Saturating so a long run never wraps back to a misleading small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_cnt <= '0;
    end else if (w_redirect && (r_redirect_cnt != {PERF_W{1'b1}})) begin
      r_redirect_cnt <= r_redirect_cnt + PERF_W'(1);
    end
  end

  assign redirect_cnt_o = r_redirect_cnt;
`else
  assign redirect_cnt_o = '0;
`endif

  assign pc_o       = r_pc;
  assign pc_byte_o  = {r_pc, 2'b00};
  assign pc_plus1_o = w_pc_plus1;
  assign valid_o    = r_valid;
  assign halted_o   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_next_unit
// Description : Self-checking bench for pc_next_unit (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt, br, jmp;
  logic [15:0] imm;
  logic [25:0] tgt;

  logic [29:0] pc0, pc1, plus1_0, plus1_1;
  logic [31:0] byte0, byte1;
  logic        valid0, valid1, halted0, halted1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  pc_next_unit #(.RESET_VEC(30'h00100000), .PERF_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .halt_i(halt),
    .branch_taken_i(br), .jump_i(jmp), .imm16_i(imm), .target26_i(tgt),
    .pc_o(pc0), .pc_byte_o(byte0), .pc_plus1_o(plus1_0),
    .valid_o(valid0), .halted_o(halted0), .redirect_cnt_o(cnt0)
  );

  pc_next_unit #(.RESET_VEC(30'h3FFFFFFF), .PERF_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .halt_i(halt),
    .branch_taken_i(br), .jump_i(jmp), .imm16_i(imm), .target26_i(tgt),
    .pc_o(pc1), .pc_byte_o(byte1), .pc_plus1_o(plus1_1),
    .valid_o(valid1), .halted_o(halted1), .redirect_cnt_o(cnt1)
  );

  typedef struct {
    logic        stall, halt, br, jmp;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [29:0] exp_pc;
  } vec_t;

  typedef struct {
    string       nm;
    logic [29:0] pc;
    logic        valid, halted;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_state;  // 0 boot, 1 run, 2 halt
  logic [15:0] m_cnt0;
  logic [1:0]  m_cnt1;
  vec_t        vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic h, input logic b, input logic j,
                        input logic [15:0] im, input logic [25:0] tg);
    stall = s; halt = h; br = b; jmp = j; imm = im; tgt = tg;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt0  = '0;
    m_cnt1  = '0;
  endtask

  task automatic tick(input string nm, input logic [29:0] exp_pc);
    exp_t e;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (halt) m_state = 2;
        else if (!stall && (jmp || br)) begin
`ifdef PC_PERF_CNT_EN
          if (m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
          if (m_cnt1 != 2'b11)    m_cnt1 = m_cnt1 + 2'd1;
`endif
        end
      end
      default: ;
    endcase
    e.nm = nm; e.pc = exp_pc; e.valid = (m_state == 1); e.halted = (m_state == 2);
    e.cnt0 = m_cnt0; e.cnt1 = m_cnt1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.nm, "/pc"},     {2'b00, pc0},            {2'b00, e.pc});
    chk({e.nm, "/plus1"},  {2'b00, plus1_0},        {2'b00, e.pc + 30'd1});
    chk({e.nm, "/byte"},   byte0,                   {e.pc, 2'b00});
    chk({e.nm, "/valid"},  {31'd0, valid0},         {31'd0, e.valid});
    chk({e.nm, "/halted"}, {31'd0, halted0},        {31'd0, e.halted});
    chk({e.nm, "/cnt0"},   {16'd0, cnt0},           {16'd0, e.cnt0});
    chk({e.nm, "/cnt1"},   {30'd0, cnt1},           {30'd0, e.cnt1});
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "/pc0"},    {2'b00, pc0},     {2'b00, 30'h00100000});
    chk({nm, "/pc1"},    {2'b00, pc1},     {2'b00, 30'h3FFFFFFF});
    chk({nm, "/valid"},  {31'd0, valid0},  32'd0);
    chk({nm, "/halted"}, {31'd0, halted0}, 32'd0);
    chk({nm, "/cnt0"},   {16'd0, cnt0},    32'd0);
    chk({nm, "/cnt1"},   {30'd0, cnt1},    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //               stall halt br   jmp   imm       tgt          exp_pc
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 26'h0000000, 30'h00100006};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 26'h0000000, 30'h00100006};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000000, 30'h00100007};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 26'h0000020, 30'h00000020};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 26'h0000000, 30'h0000001F};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 26'h3FFFFFF, 30'h0000001F};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h3FFFFFF, 30'h03FFFFFF};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000000, 30'h04000000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0000010, 30'h04000010};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h8000, 26'h0000000, 30'h03FF8011};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h7FFF, 26'h0000000, 30'h04000011};

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    model_reset();
    @(negedge clk);
    chk_reset("reset");

    // BOOT cycle ignores a jump request; PC held, valid rises afterwards.
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0000055);
    tick("boot", 30'h00100000);
    chk("boot/pc1", {2'b00, pc1}, {2'b00, 30'h3FFFFFFF});
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    tick("seq1", 30'h00100001);
    chk("wrap/pc1",   {2'b00, pc1}, 32'd0);
    chk("wrap/byte1", byte1,        32'd0);

    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].stall, vecs[i].halt, vecs[i].br, vecs[i].jmp, vecs[i].imm, vecs[i].tgt);
      tick($sformatf("vec%0d", i), vecs[i].exp_pc);
    end

    // Halt wins over a simultaneous stall and redirect; then frozen.
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 26'h0000123);
    tick("halt", 30'h04000011);
    for (int i = 0; i < 4; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             16'($urandom), 26'($urandom));
      tick($sformatf("frozen%0d", i), 30'h04000011);
    end

    // Asynchronous reset mid-HALT, no clock edge in between.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset("rst_halt");
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 26'h0000099);
    tick("boot2", 30'h00100000);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    tick("seq2a", 30'h00100001);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 26'h0);
    tick("br2", 30'h00100004);

    // Asynchronous reset mid-RUN.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset("rst_run");
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    tick("boot3", 30'h00100000);
    tick("seq3", 30'h00100001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
